// File: rtl/right_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : right_shift_pkg
// Description : Shared definitions for the right_shift_n block. Holds the
//               two-bit shift-mode encodings used on the mode port.
// Revision    : 1.0 - initial release
// ============================================================================
package right_shift_pkg;

    // Shift-kind selector carried on the mode port.
    typedef enum logic [1:0] {
        LOGICAL = 2'b00,   // zero fill
        ARITH   = 2'b01,   // sign fill from the operand MSB
        ROTATE  = 2'b10,   // bits leaving bit 0 re-enter at the top
        HOLD    = 2'b11    // keep the previous result
    } shift_mode_e;

    localparam int MODE_W = 2;

endpackage : right_shift_pkg
`default_nettype wire

// File: rtl/right_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : right_shift_core
// Description : Purely combinational fixed-distance right shifter. Produces a
//               logical, arithmetic or rotate shift of the operand by N bits.
//               The HOLD code passes the operand through; the register stage
//               in the parent decides whether the value is captured.
// Ports       : a       - operand (WIDTH bits)
//               mode    - shift kind (see right_shift_pkg)
//               shifted - shift result (WIDTH bits)
// Revision    : 1.0 - initial release
// ============================================================================
module right_shift_core
    import right_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 1
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  shifted
);

    // A rotate by WIDTH is the identity, so only the remainder matters.
    localparam int c_rot_dist = N % WIDTH;

    logic [WIDTH-1:0] w_logical;
    logic [WIDTH-1:0] w_arith;
    logic [WIDTH-1:0] w_rotate;

    // Shifts by an amount >= WIDTH already give all-zero (logical) and
    // all-sign (arithmetic) results, which covers the N = WIDTH corner.
    assign w_logical = a >> N;
    assign w_arith   = WIDTH'($signed(a) >>> N);
    // With c_rot_dist = 0 the left term shifts by WIDTH and vanishes.
    assign w_rotate  = (a >> c_rot_dist) | (a << (WIDTH - c_rot_dist));

    always_comb begin
        shifted = a;
        case (mode)
            LOGICAL: shifted = w_logical;
            ARITH:   shifted = w_arith;
            ROTATE:  shifted = w_rotate;
            default: shifted = a;
        endcase
    end

endmodule : right_shift_core
`default_nettype wire

// File: rtl/right_shift_n.sv
`default_nettype none
// ============================================================================
// Module      : right_shift_n
// Description : Registered fixed-distance right shifter with one cycle of
//               latency and full throughput. The shift datapath lives in
//               right_shift_core; this level holds only the output registers.
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               in_valid  - operand a is valid this cycle
//               mode      - shift kind (logical/arith/rotate/hold)
//               a         - operand (WIDTH bits)
//               out       - registered result (WIDTH bits)
//               out_valid - one-cycle pulse per accepted operand
// Revision    : 1.0 - initial release
// ============================================================================
module right_shift_n
    import right_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid
);

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("right_shift_n: WIDTH=%0d outside legal range 2..64", WIDTH);
        end
        if (N < 0 || N > WIDTH) begin : g_bad_shift
            $error("right_shift_n: N=%0d outside legal range 0..WIDTH", N);
        end
    endgenerate

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

    right_shift_core #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_core (
        .a       (a),
        .mode    (mode),
        .shifted (w_shifted)
    );

    // HOLD still produces a valid pulse but leaves the result untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid && (mode != HOLD)) begin
                r_out <= w_shifted;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule : right_shift_n
`default_nettype wire

// File: tb/tb_right_shift_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_right_shift_n
// Description : Directed self-checking bench for right_shift_n. Six WIDTH=32
//               instances with N = 0, 1, 2, 4, 16, 32 share one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_right_shift_n;
    import right_shift_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  mode;
    logic [31:0] a;

    logic [31:0] o0, o1, o2, o4, o16, o32;
    logic        v0, v1, v2, v4, v16, v32;
    logic [31:0] obs [6];
    logic        vobs [6];

    int checks = 0;
    int errors = 0;

    assign obs[0] = o0;  assign obs[1] = o1;  assign obs[2] = o2;
    assign obs[3] = o4;  assign obs[4] = o16; assign obs[5] = o32;
    assign vobs[0] = v0; assign vobs[1] = v1; assign vobs[2] = v2;
    assign vobs[3] = v4; assign vobs[4] = v16; assign vobs[5] = v32;

    right_shift_n #(.WIDTH(32), .N(0))  dut_n0  (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .a(a), .out(o0),  .out_valid(v0));
    right_shift_n #(.WIDTH(32), .N(1))  dut_n1  (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .a(a), .out(o1),  .out_valid(v1));
    right_shift_n #(.WIDTH(32), .N(2))  dut_n2  (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .a(a), .out(o2),  .out_valid(v2));
    right_shift_n #(.WIDTH(32), .N(4))  dut_n4  (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .a(a), .out(o4),  .out_valid(v4));
    right_shift_n #(.WIDTH(32), .N(16)) dut_n16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .a(a), .out(o16), .out_valid(v16));
    right_shift_n #(.WIDTH(32), .N(32)) dut_n32 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .a(a), .out(o32), .out_valid(v32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Present inputs on the falling edge, then sample 1 time unit after the
    // following rising edge.
    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] x);
        @(negedge clk);
        in_valid = v;
        mode     = m;
        a        = x;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; mode = LOGICAL; a = '0;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== 32'h0 || vobs[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: out=%h valid=%b, required out=0 valid=0", i, obs[i], vobs[i]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_logical();
        logic [31:0] exp_neg3 [6] = '{32'hFFFFFFFD, 32'h7FFFFFFE, 32'h3FFFFFFF, 32'h0FFFFFFF, 32'h0000FFFF, 32'h00000000};
        logic [31:0] exp_pos3 [6] = '{32'h3, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
        drive(1'b1, LOGICAL, 32'hFFFFFFFD);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== exp_neg3[i] || vobs[i] !== 1'b1) begin
                errors++;
                $display("FAIL logical_neg3[%0d]: out=%h valid=%b, required out=%h valid=1", i, obs[i], vobs[i], exp_neg3[i]);
            end
        end
        drive(1'b1, LOGICAL, 32'h3);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== exp_pos3[i]) begin
                errors++;
                $display("FAIL logical_pos3[%0d]: out=%h, required %h", i, obs[i], exp_pos3[i]);
            end
        end
    endtask

    task automatic test_arith();
        logic [31:0] exp_neg3 [6] = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp_min  [6] = '{32'h80000000, 32'hC0000000, 32'hE0000000, 32'hF8000000, 32'hFFFF8000, 32'hFFFFFFFF};
        logic [31:0] exp_pos3 [6] = '{32'h3, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
        drive(1'b1, ARITH, 32'hFFFFFFFD);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== exp_neg3[i]) begin
                errors++;
                $display("FAIL arith_neg3[%0d]: out=%h, required %h", i, obs[i], exp_neg3[i]);
            end
        end
        drive(1'b1, ARITH, 32'h80000000);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== exp_min[i]) begin
                errors++;
                $display("FAIL arith_min[%0d]: out=%h, required %h", i, obs[i], exp_min[i]);
            end
        end
        drive(1'b1, ARITH, 32'h3);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== exp_pos3[i]) begin
                errors++;
                $display("FAIL arith_pos3[%0d]: out=%h, required %h", i, obs[i], exp_pos3[i]);
            end
        end
    endtask

    task automatic test_rotate();
        logic [31:0] exp_neg3 [6] = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'hDFFFFFFF, 32'hFFFDFFFF, 32'hFFFFFFFD};
        logic [31:0] exp_pos3 [6] = '{32'h3, 32'h80000001, 32'hC0000000, 32'h30000000, 32'h00030000, 32'h3};
        drive(1'b1, ROTATE, 32'hFFFFFFFD);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== exp_neg3[i]) begin
                errors++;
                $display("FAIL rotate_neg3[%0d]: out=%h, required %h", i, obs[i], exp_neg3[i]);
            end
        end
        drive(1'b1, ROTATE, 32'h3);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== exp_pos3[i]) begin
                errors++;
                $display("FAIL rotate_pos3[%0d]: out=%h, required %h", i, obs[i], exp_pos3[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops    [7] = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'h3};
        logic [31:0] exp_n1 [7] = '{32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h1, 32'h80000001};
        logic [31:0] exp_n4 [7] = '{32'hDFFFFFFF, 32'hEFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h10000000, 32'h20000000, 32'h30000000};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ROTATE, ops[i]);
            checks++;
            if (o1 !== exp_n1[i] || o4 !== exp_n4[i] || v1 !== 1'b1) begin
                errors++;
                $display("FAIL stream[%0d]: n1=%h n4=%h valid=%b, required n1=%h n4=%h valid=1",
                         i, o1, o4, v1, exp_n1[i], exp_n4[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, LOGICAL, 32'hA5A5A5A5);
            checks++;
            if (o1 !== 32'h80000001 || o4 !== 32'h30000000 || v1 !== 1'b0) begin
                errors++;
                $display("FAIL stream_idle[%0d]: n1=%h n4=%h valid=%b, required n1=80000001 n4=30000000 valid=0",
                         i, o1, o4, v1);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b1, HOLD, 32'h12345678);
        checks++;
        if (o1 !== 32'h80000001 || o0 !== 32'h3 || v1 !== 1'b1) begin
            errors++;
            $display("FAIL hold_valid: n1=%h n0=%h valid=%b, required n1=80000001 n0=00000003 valid=1", o1, o0, v1);
        end
        drive(1'b0, HOLD, 32'h12345678);
        checks++;
        if (o1 !== 32'h80000001 || v1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: n1=%h valid=%b, required n1=80000001 valid=0", o1, v1);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, LOGICAL, 32'hFFFFFFFD);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== 32'h0 || vobs[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset[%0d]: out=%h valid=%b, required out=0 valid=0", i, obs[i], vobs[i]);
            end
        end
        drive(1'b1, LOGICAL, 32'h3);
        checks++;
        if (o1 !== 32'h0 || v1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: out=%h valid=%b, required out=0 valid=0", o1, v1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (o1 !== 32'h1 || o2 !== 32'h0 || v1 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: n1=%h n2=%h valid=%b, required n1=00000001 n2=00000000 valid=1", o1, o2, v1);
        end
        drive(1'b0, LOGICAL, 32'h0);
        checks++;
        if (o1 !== 32'h1 || v1 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: out=%h valid=%b, required out=00000001 valid=0", o1, v1);
        end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith();
        test_rotate();
        test_back_to_back();
        test_hold();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_right_shift_n
`default_nettype wire

// File: doc/right_shift_n.md
RIGHT_SHIFT_N -- requirements
Module: right_shift_n

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits (legal values 2..64).
REQ-002 Parameter N, default 1, fixed right-shift distance in bits (legal values 0..WIDTH).
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  high marks a as a valid operand this cycle.
REQ-006 Port mode  input  2  shift kind:
- 00 logical
- 01 arithmetic
- 10 rotate
- 11 hold
REQ-007 Port a  input  WIDTH  operand, treated as unsigned bit vector except in arithmetic mode.
REQ-008 Port out  output  WIDTH  registered shift result.
REQ-009 Port out_valid  output  1  high for exactly the cycle in which out holds a new result.

Function
REQ-010 The block SHALL register its result with a latency of one clk cycle: inputs sampled at edge k appear on out/out_valid after edge k.
REQ-011 When in_valid=1 at an edge, out_valid SHALL be 1 after that edge; otherwise out_valid SHALL be 0.
REQ-012 When in_valid=0, out SHALL retain its previous value.
REQ-013 Logical mode SHALL produce a >> N with zero fill; N=WIDTH yields all zeros.
REQ-014 Arithmetic mode SHALL produce a >> N with a[WIDTH-1] replicated into the vacated upper N bits; N=WIDTH yields all bits equal to a[WIDTH-1].
REQ-015 Rotate mode SHALL move bits shifted out of bit 0 into the top; the effective distance is N mod WIDTH.
REQ-016 Hold mode with in_valid=1 SHALL leave out unchanged and still assert out_valid for one cycle.
REQ-017 N=0 SHALL pass a through unchanged in modes 00, 01 and 10.
REQ-018 The datapath SHALL be purely combinational from a/mode to the out register D input; no internal multi-cycle state.
REQ-019 Back-to-back valid inputs on consecutive cycles SHALL each produce a result; there is no backpressure and throughput is 1 per cycle.

Reset
REQ-020 While rst_n=0, out SHALL be 0 and out_valid SHALL be 0, immediately and independent of clk.
REQ-021 Deassertion of rst_n SHALL take effect at the next rising clk edge; an in_valid sampled on that edge is processed normally.
REQ-022 Reset asserted mid-stream SHALL discard any in-flight result; no out_valid pulse follows for it.

Structure
REQ-023 The mode encodings (LOGICAL=00, ARITH=01, ROTATE=10, HOLD=11) SHALL be constants in a shared package, right_shift_pkg.
REQ-024 One combinational sub-module, right_shift_core (parameters WIDTH, N; inputs a and mode; output shifted value), SHALL hold the datapath; the top holds only the registers.
REQ-025 Illegal parameter values SHALL be rejected at elaboration with an error.

Verification
REQ-026 WIDTH=32, N=1, logical, a=0xFFFFFFFD (-3) -> out=0x7FFFFFFE with out_valid=1 one cycle later.
REQ-027 Same operand, arithmetic, N=1 -> 0xFFFFFFFE; N=16 -> 0xFFFFFFFF; logical N=16 -> 0x0000FFFF.
REQ-028 Operands a=3 with N=1, 2, 4 and logical mode -> 0x1, 0x0, 0x0; rotate with N=1 -> 0x80000001.
REQ-029 Stream a = -3..3 on seven consecutive valid cycles -> seven consecutive out_valid pulses with the correct results in order; then in_valid=0 -> out holds and out_valid=0.
REQ-030 Assert rst_n=0 between clock edges while out is nonzero -> out=0 and out_valid=0 immediately; after release, the first valid input is processed with one-cycle latency.
